// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types, default sizes and helpers for the register-file writeback arbiter.
package regfile_wb_pkg;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_NUM_WP  = 3;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 64;

  localparam int PTR_W = $clog2(DEF_NUM_SRC);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  // Rotating index: (base + off) wrapped into 0..n-1.
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Source handshake and register-file write-port bundle for regfile_wb_arbiter.
// slave: the arbiter side; master: the functional units / register file side.
interface regfile_wb_arbiter_if
  import regfile_wb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int NUM_WP  = DEF_NUM_WP,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) ();

  logic [NUM_SRC-1:0]             io_src_valid;
  logic [NUM_SRC-1:0]             io_src_ready;
  logic [NUM_SRC-1:0][ADDR_W-1:0] io_src_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] io_src_data;

  logic [NUM_WP-1:0]              io_write_ports_valid;
  logic [NUM_WP-1:0][ADDR_W-1:0]  io_write_ports_bits_addr;
  logic [NUM_WP-1:0][DATA_W-1:0]  io_write_ports_bits_data;

  modport slave (
    input  io_src_valid, io_src_addr, io_src_data,
    output io_src_ready,
    output io_write_ports_valid, io_write_ports_bits_addr, io_write_ports_bits_data
  );

  modport master (
    output io_src_valid, io_src_addr, io_src_data,
    input  io_src_ready,
    input  io_write_ports_valid, io_write_ports_bits_addr, io_write_ports_bits_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational multi-grant round-robin selector. Scans buffered entries from
// rr_ptr, consumes address-0 entries without a port, skips entries whose
// address is already granted this cycle, and packs grants onto ports in order.
module wb_rr_multi_grant
  import regfile_wb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int NUM_WP  = DEF_NUM_WP,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic [NUM_SRC-1:0]                     buf_valid_i,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]         buf_addr_i,
  input  logic [$clog2(NUM_SRC)-1:0]             rr_ptr_i,
  output logic [NUM_SRC-1:0]                     grant_o,
  output logic [NUM_WP-1:0][$clog2(NUM_SRC)-1:0] port_src_o,
  output logic [NUM_WP-1:0]                      port_vld_o
);

  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_WP-1:0][ADDR_W-1:0] port_addr;
  logic [SW-1:0]                 idx;
  logic                          hit;
  int                            used;

  // Priority scan: grant in rotated order until every write port is taken
  always_comb begin
    grant_o    = '0;
    port_src_o = '0;
    port_vld_o = '0;
    port_addr  = '0;
    idx        = '0;
    hit        = 1'b0;
    used       = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      idx = SW'(wrap_add(int'(rr_ptr_i), s, NUM_SRC));
      hit = 1'b0;
      for (int p = 0; p < NUM_WP; p++) begin
        if (port_vld_o[p] && (port_addr[p] == buf_addr_i[idx])) hit = 1'b1;
      end
      if (buf_valid_i[idx]) begin
        if (buf_addr_i[idx] == '0) begin
          // Writes to register 0 are discarded, so they never need a port.
          grant_o[idx] = 1'b1;
        end else if (!hit && (used < NUM_WP)) begin
          grant_o[idx] = 1'b1;
          for (int p = 0; p < NUM_WP; p++) begin
            if (p == used) begin
              port_vld_o[p] = 1'b1;
              port_src_o[p] = idx;
              port_addr[p]  = buf_addr_i[idx];
            end
          end
          used = used + 1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback front end for the integer physical register file: one-entry buffer
// per source, rotating multi-grant onto NUM_WP registered write ports, and no
// two ports ever carry the same nonzero address in a cycle.
// Optional feature macro: REGFILE_WB_PERF_EN enables the 32-bit saturating
// stall counter on io_perf_stall_count; otherwise that output is tied to 0.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int NUM_WP  = DEF_NUM_WP,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  output logic [31:0]          io_perf_stall_count
);

  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]             buf_valid_q;
  logic [NUM_SRC-1:0][ADDR_W-1:0] buf_addr_q;
  logic [NUM_SRC-1:0][DATA_W-1:0] buf_data_q;
  logic [SW-1:0]                  rr_ptr_q;
  logic [SW-1:0]                  rr_ptr_d;

  logic [NUM_SRC-1:0]             grant;
  logic [NUM_SRC-1:0]             src_ready;
  logic [NUM_SRC-1:0]             src_xfer;
  logic [NUM_WP-1:0][SW-1:0]      port_src;
  logic [NUM_WP-1:0]              port_vld;

  logic [NUM_WP-1:0]              wp_valid_q;
  logic [NUM_WP-1:0][ADDR_W-1:0]  wp_addr_q;
  logic [NUM_WP-1:0][DATA_W-1:0]  wp_data_q;

  // Ready depends only on buffer state and grant, never on the source inputs.
  assign src_ready       = ~buf_valid_q | grant;
  assign src_xfer        = wb.io_src_valid & src_ready;
  assign wb.io_src_ready = src_ready;

  wb_rr_multi_grant #(
    .NUM_SRC (NUM_SRC),
    .NUM_WP  (NUM_WP),
    .ADDR_W  (ADDR_W)
  ) u_grant (
    .buf_valid_i (buf_valid_q),
    .buf_addr_i  (buf_addr_q),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .port_src_o  (port_src),
    .port_vld_o  (port_vld)
  );

  // Buffer occupancy: a granted entry frees, a transfer (possibly same edge) refills
  always_ff @(posedge clock or posedge reset) begin
    if (reset) buf_valid_q <= '0;
    else       buf_valid_q <= src_xfer | (buf_valid_q & ~grant);
  end

  // Buffer payload captures on each accepted transfer
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_xfer[i]) begin
        buf_addr_q[i] <= wb.io_src_addr[i];
        buf_data_q[i] <= wb.io_src_data[i];
      end
    end
  end

  // Next pointer: one past the last port-using grant; ports fill in scan order
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_WP; k++) begin
      if (port_vld[k]) rr_ptr_d = SW'(wrap_add(int'(port_src[k]), 1, NUM_SRC));
    end
  end

  // Rotating-priority pointer register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  // Write-port enables
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wp_valid_q <= '0;
    else       wp_valid_q <= port_vld;
  end

  // Write-port address/data; idle ports keep their last value
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_WP; k++) begin
      if (port_vld[k]) begin
        wp_addr_q[k] <= buf_addr_q[port_src[k]];
        wp_data_q[k] <= buf_data_q[port_src[k]];
      end
    end
  end

  assign wb.io_write_ports_valid     = wp_valid_q;
  assign wb.io_write_ports_bits_addr = wp_addr_q;
  assign wb.io_write_ports_bits_data = wp_data_q;

`ifdef REGFILE_WB_PERF_EN
  logic [NUM_SRC-1:0] nz_pend;
  logic [31:0]        stall_cnt_q;

  // Nonzero entries left waiting this cycle
  always_comb begin
    nz_pend = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nz_pend[i] = buf_valid_q[i] & (buf_addr_q[i] != '0) & ~grant[i];
    end
  end

  // Saturating stall counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((|nz_pend) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign io_perf_stall_count = stall_cnt_q;
`else
  assign io_perf_stall_count = 32'd0;
`endif

endmodule
